// File: rtl/seg7_digit_sequencer_if.sv
// Pin bundle of the TinyTapeout user slot driven by the digit sequencer.
// io_in carries clock, reset and the user inputs; io_out the display.
interface seg7_digit_sequencer_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (
    output io_in,
    input  io_out
  );

  modport slave (
    input  io_in,
    output io_out
  );
endinterface

// File: rtl/seg7_digit_sequencer.sv
// Single-digit BCD up/down counter with a push-button mode FSM,
// parallel load, and a registered 7-segment plus wrap-dp output.
module seg7_digit_sequencer #(
  parameter int TICK_DIV    = 1000,
  parameter int SYNC_STAGES = 2
) (
  seg7_digit_sequencer_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } mode_e;

  logic clk;
  logic rst_n;
  assign clk   = bus.io_in[0];
  assign rst_n = bus.io_in[1];

  logic [5:0]    sync_q [SYNC_STAGES];
  logic          btn_prev_q;
  mode_e         mode_q, mode_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    digit_q, digit_d;
  logic          dp_q, dp_d;
  logic [6:0]    seg_q, seg_d;

  logic       btn_s, load_s;
  logic [3:0] ld_s;
  logic       btn_rise, run, tick;

  assign btn_s  = sync_q[SYNC_STAGES-1][0];
  assign load_s = sync_q[SYNC_STAGES-1][1];
  assign ld_s   = sync_q[SYNC_STAGES-1][5:2];

  assign btn_rise = btn_s & ~btn_prev_q;
  assign run      = (mode_q != HOLD) & ~load_s;
  assign tick     = run & (pre_q == TMAX);

  always_comb begin
    mode_d  = mode_q;
    pre_d   = pre_q + 1'b1;
    digit_d = digit_q;
    dp_d    = dp_q;
    seg_d   = 7'h00;

    if (btn_rise) begin
      unique case (mode_q)
        HOLD:    mode_d = UP;
        UP:      mode_d = DOWN;
        default: mode_d = HOLD;
      endcase
    end

    if (!run || btn_rise || tick) pre_d = '0;

    // load wins over tick; out-of-range load values are ignored
    if (load_s) begin
      if (ld_s <= 4'd9) digit_d = ld_s;
    end else if (tick) begin
      if (mode_q == UP) begin
        if (digit_q == 4'd9) begin
          digit_d = 4'd0;
          dp_d    = ~dp_q;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        if (digit_q == 4'd0) begin
          digit_d = 4'd9;
          dp_d    = ~dp_q;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end

    case (digit_q)
      4'd0:    seg_d = 7'h3F;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5B;
      4'd3:    seg_d = 7'h4F;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6D;
      4'd6:    seg_d = 7'h7D;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7F;
      4'd9:    seg_d = 7'h6F;
      default: seg_d = 7'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      btn_prev_q <= 1'b0;
      mode_q     <= HOLD;
      pre_q      <= '0;
      digit_q    <= 4'd0;
      dp_q       <= 1'b0;
      seg_q      <= 7'h3F;
    end else begin
      sync_q[0] <= bus.io_in[7:2];
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      btn_prev_q <= btn_s;
      mode_q     <= mode_d;
      pre_q      <= pre_d;
      digit_q    <= digit_d;
      dp_q       <= dp_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.io_out = {dp_q, seg_q};

endmodule

// File: tb/tb_seg7_digit_sequencer.sv
// Randomized and directed bench for seg7_digit_sequencer against a
// cycle-level behavioural model of the digit counter.
module tb_seg7_digit_sequencer;

  localparam int T = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] ld_val = 4'd0;

  int checks = 0;
  int errors = 0;

  seg7_digit_sequencer_if bus ();
  assign bus.io_in = {ld_val, load, btn, rst_n, clk};

  seg7_digit_sequencer #(
    .TICK_DIV    (T),
    .SYNC_STAGES (S)
  ) dut (
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] lut_t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // model state: mode 0=HOLD 1=UP 2=DOWN
  int         mmode, mdig, mcnt;
  logic       mdp, mprev;
  logic [6:0] mseg;
  logic [5:0] hist [S];

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic mreset();
    mmode = 0; mdig = 0; mcnt = 0;
    mdp = 1'b0; mprev = 1'b0; mseg = 7'h3F;
    for (int i = 0; i < S; i++) hist[i] = '0;
  endtask

  task automatic model_edge();
    logic [5:0] s;
    logic rise, active, tick;
    if (!rst_n) begin
      mreset();
      return;
    end
    s      = hist[S-1];
    rise   = s[0] && !mprev;
    active = (mmode != 0) && !s[1];
    tick   = active && (mcnt == T - 1);
    mseg   = lut_t[mdig];
    if (s[1]) begin
      if (s[5:2] < 10) mdig = int'(s[5:2]);
    end else if (tick) begin
      if (mmode == 1) begin
        if (mdig == 9) mdp = ~mdp;
        mdig = (mdig + 1) % 10;
      end else begin
        if (mdig == 0) mdp = ~mdp;
        mdig = (mdig + 9) % 10;
      end
    end
    mcnt = (!active || rise) ? 0 : (mcnt + 1) % T;
    if (rise) mmode = (mmode + 1) % 3;
    mprev = s[0];
    for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {ld_val, load, btn};
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("seg", {1'b0, bus.io_out[6:0]}, {1'b0, mseg});
      chk("dp", {7'b0, bus.io_out[7]}, {7'b0, mdp});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mreset();
    btn = 1'b0; load = 1'b0; ld_val = 4'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic press(input int w);
    btn = 1'b1;
    cyc(w);
    btn = 1'b0;
  endtask

  initial begin
    int guard;
    mreset();
    #1 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(50);
    chk("rst_seg", {1'b0, bus.io_out[6:0]}, 8'h3F);
    chk("rst_dp", {7'b0, bus.io_out[7]}, 8'h00);

    // count up through the wrap with one long press
    press(10);
    cyc(44);

    // up then down, then freeze
    do_reset();
    press(3); cyc(5);
    press(3); cyc(20);
    press(3); cyc(40);

    // load 7 in UP mode, then release
    do_reset();
    press(3); cyc(6);
    ld_val = 4'd7; load = 1'b1;
    cyc(20);
    chk("load7", {1'b0, bus.io_out[6:0]}, 8'h07);
    load = 1'b0;
    cyc(10);

    // illegal load value leaves digit 3 untouched
    do_reset();
    ld_val = 4'd3; load = 1'b1; cyc(5);
    load = 1'b0; cyc(3);
    ld_val = 4'd12; load = 1'b1; cyc(10);
    chk("ld_bad_seg", {1'b0, bus.io_out[6:0]}, 8'h4F);
    chk("ld_bad_dp", {7'b0, bus.io_out[7]}, 8'h00);
    load = 1'b0; cyc(3);

    // button rise lands on the 9->0 wrap tick
    do_reset();
    press(3);
    guard = 0;
    while (!(mmode == 1 && mdig == 9 && mcnt == T - 1 - S) && guard < 200) begin
      cyc(1);
      guard++;
    end
    chk("wrap_found", {7'b0, guard < 200}, 8'h01);
    btn = 1'b1;
    cyc(S + 2);
    btn = 1'b0;
    chk("wrap_seg", {1'b0, bus.io_out[6:0]}, 8'h3F);
    chk("wrap_dp", {7'b0, bus.io_out[7]}, 8'h01);
    cyc(12);

    // asynchronous reset in the middle of counting
    do_reset();
    press(3);
    guard = 0;
    while (mdig != 5 && guard < 200) begin
      cyc(1);
      guard++;
    end
    cyc(2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_seg", {1'b0, bus.io_out[6:0]}, 8'h3F);
    chk("arst_dp", {7'b0, bus.io_out[7]}, 8'h00);
    mreset();
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) btn = ~btn;
      if ($urandom_range(0, 29) == 0) load = ~load;
      if ($urandom_range(0, 7) == 0) ld_val = 4'($urandom_range(0, 15));
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
